ball_engine: RTL and testbench
==============================

# ball_engine

Drives the pong ball: owns the ball's position and direction, steps it one pixel per move tick, bounces it off the top and bottom walls and both paddles, and flags a point when it leaves the court. It produces the `BALL_H`/`BALL_V` bus that the computer-player block and the video renderer consume. It also consumes both paddles' 8-bit `POSITION` values (2 px resolution).

## Interface
- `SCREEN_W`, default 800: court width in pixels.
- `SCREEN_H`, default 480: court height in pixels.
- `BALL_SIZE`, default 6: ball edge length; maximum `BALL_V` = `SCREEN_H-BALL_SIZE` = 474.
- `PADDLE_LEN`, default 80: paddle height in pixels.
- `PADDLE_W`, default 6: paddle width in pixels.
- `LEFT_X`, default 10: left paddle leftmost column.
- `RIGHT_X`, default 784: right paddle leftmost column.
- `SERVE_H`, default 397: serve column.
- `SERVE_V`, default 237: serve row.
- `TICK_DIV`, default 500000: clock cycles per ball move; must be ≥ 4.
- `SERVE_TICKS`, default 120: move ticks the ball holds at the serve point before moving.
- `CLOCK`  in  1  system clock.
- `RESET`  in  1  asynchronous, active-high reset.
- `ENABLE`  in  1  high = game runs; low freezes the tick counter and the ball.
- `LEFT_POS`  in  8  left (player) paddle top row / 2.
- `RIGHT_POS`  in  8  right (AI) paddle top row / 2.
- `BALL_H`  out  11  ball left column, registered.
- `BALL_V`  out  11  ball top row, registered.
- `SCORE_LEFT`  out  1  one-cycle pulse: left player scored (ball exited right).
- `SCORE_RIGHT`  out  1  one-cycle pulse: right player scored (ball exited left).

## Operation
- **Tick counter**
  - Counts 0..`TICK_DIV-1`, then wraps to 0.
  - `tick` is asserted when the count equals `TICK_DIV-1` and `ENABLE`=1.
  - All ball updates happen only on `tick`.
- **Direction state**
  - `dir_h`: 1 = increasing `BALL_H`.
  - `dir_v`: 1 = increasing `BALL_V`.
- **State machine**
  - SERVE: ball is held at (`SERVE_H`,`SERVE_V`) and a serve counter counts ticks. After `SERVE_TICKS` ticks the block goes to MOVE.
  - MOVE: on each tick, resolve reflections first, then move exactly ±1 in H and ±1 in V.
    - This fixed 45° motion is required: every column is visited for a full tick, so downstream blocks can sample consecutive columns.
  - SCORED: lasts one cycle. The matching score pulse is asserted, the ball is loaded to the serve point, and the block goes to SERVE.
- **Vertical reflection**
  - If `dir_v`=1 and `BALL_V`=474, clear `dir_v` before moving.
  - If `dir_v`=0 and `BALL_V`=0, set `dir_v` before moving.
- **Paddle hit test**
  - Paddle top = `{POS,1'b0}` (9 bits, zero-extended to 11).
  - Vertical overlap condition: `BALL_V+BALL_SIZE > top` and `BALL_V < top+PADDLE_LEN`.
  - Left paddle hit: `dir_h`=0, `BALL_H`=`LEFT_X+PADDLE_W`, and overlap → set `dir_h`.
  - Right paddle hit: `dir_h`=1, `BALL_H+BALL_SIZE`=`RIGHT_X`, and overlap → clear `dir_h`.
- **Scoring**
  - If `dir_h`=0 and `BALL_H`=0 with no hit, the right player scores: go to SCORED, pulse `SCORE_RIGHT`, serve with `dir_h`=0.
  - If `dir_h`=1 and `BALL_H`=`SCREEN_W-BALL_SIZE` with no hit, the left player scores: go to SCORED, pulse `SCORE_LEFT`, serve with `dir_h`=1.
  - After a score the ball is served toward the player who conceded. `dir_v` is kept.
- **Simultaneous events**
  - A wall and a paddle reflection on the same tick both apply; the resulting diagonal move uses both new directions.
  - A paddle hit takes precedence over scoring.
- All arithmetic is done 11 bits wide, with no wrap. The ball never leaves 0..794 × 0..474.

## Timing
- **Reset values**
  - `BALL_H`=397, `BALL_V`=237, `SCORE_*`=0.
  - State SERVE, serve counter 0, tick counter 0.
  - `dir_h`=1 (toward the AI), `dir_v`=1.
- **Update timing**
  - `BALL_H`/`BALL_V` change on the clock edge after the cycle where `tick` is asserted, then hold for `TICK_DIV` cycles.
  - The paddle inputs are sampled in the `tick` cycle only.
- **Score timing**
  - The score pulse is asserted for exactly 1 cycle, in the cycle after the exit tick.
  - `BALL_H`/`BALL_V` show the serve point from that same cycle.
- **ENABLE**
  - Deasserting `ENABLE` freezes the tick count and all state. Reasserting it resumes from the frozen count.
  - A SCORED state already entered still completes its pulse regardless of `ENABLE`.
- **Reset mid-operation**: `RESET` asserted mid-move or mid-serve forces all reset values immediately. No score pulse is generated.

## Test plan
(All with `TICK_DIV`=4 and `SERVE_TICKS`=2.)
- **Reset**: reset, then release → ball at (397,237) for 2 ticks (8 cycles). Next tick → (398,238). It then advances +1/+1 every 4 cycles.
- **Bottom wall**: force ball (500,473) with `dir_v`=1 → next positions (501,474), (502,473). `dir_h` is unchanged.
- **Right paddle hit**: ball reaching `BALL_H`=778 moving right with `RIGHT_POS`=100 (top 200) and `BALL_V`=230 → next `BALL_H`=777. No score pulse.
- **Right paddle miss**: same as the hit case but `RIGHT_POS`=0 → ball reaches 794. On the next tick, `SCORE_LEFT` is high for 1 cycle, ball is at (397,237), and serve moves toward +H.
- **Corner plus paddle**: `BALL_V`=0 moving up with a left paddle hit at `BALL_H`=16 → next position (17,1).
- **Freeze and reset**: `ENABLE` low for 20 cycles mid-move → position unchanged and the tick phase resumes. `RESET` pulsed mid-move → immediate (397,237) with no `SCORE_*` pulse.

Source files
------------

// File: rtl/ball_engine_if.sv
// Ball engine bus: run enable and paddle rows in, ball position and score pulses out.
interface ball_engine_if;
  logic        ENABLE;
  logic [7:0]  LEFT_POS;
  logic [7:0]  RIGHT_POS;
  logic [10:0] BALL_H;
  logic [10:0] BALL_V;
  logic        SCORE_LEFT;
  logic        SCORE_RIGHT;

  modport master (output ENABLE, LEFT_POS, RIGHT_POS,
                  input  BALL_H, BALL_V, SCORE_LEFT, SCORE_RIGHT);
  modport slave  (input  ENABLE, LEFT_POS, RIGHT_POS,
                  output BALL_H, BALL_V, SCORE_LEFT, SCORE_RIGHT);
endinterface

// File: rtl/ball_engine.sv
// Pong ball engine: diagonal one-pixel steps per move tick, wall/paddle bounces,
// and a one-cycle score pulse with re-serve when the ball leaves the court.
module ball_engine #(
  parameter int unsigned SCREEN_W    = 800,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_SIZE   = 6,
  parameter int unsigned PADDLE_LEN  = 80,
  parameter int unsigned PADDLE_W    = 6,
  parameter int unsigned LEFT_X      = 10,
  parameter int unsigned RIGHT_X     = 784,
  parameter int unsigned SERVE_H     = 397,
  parameter int unsigned SERVE_V     = 237,
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned SERVE_TICKS = 120
) (
  input  logic         CLOCK,
  input  logic         RESET,
  ball_engine_if.slave io_bus
);
  localparam int unsigned W  = 11;
  localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = $clog2(SERVE_TICKS + 2);

  localparam logic [W-1:0]  MAX_H       = W'(SCREEN_W - BALL_SIZE);
  localparam logic [W-1:0]  MAX_V       = W'(SCREEN_H - BALL_SIZE);
  localparam logic [W-1:0]  BALL_SZ     = W'(BALL_SIZE);
  localparam logic [W-1:0]  PAD_LEN     = W'(PADDLE_LEN);
  localparam logic [W-1:0]  LEFT_HIT_H  = W'(LEFT_X + PADDLE_W);
  localparam logic [W-1:0]  RIGHT_HIT_H = W'(RIGHT_X - BALL_SIZE);
  localparam logic [W-1:0]  SRV_H       = W'(SERVE_H);
  localparam logic [W-1:0]  SRV_V       = W'(SERVE_V);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SERVE_LAST  = SW'(SERVE_TICKS - 1);

  typedef enum logic [1:0] {
    S_SERVE  = 2'd0,
    S_MOVE   = 2'd1,
    S_SCORED = 2'd2
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_serve_cnt;
  logic [W-1:0]  r_h;
  logic [W-1:0]  r_v;
  logic          r_dir_h;
  logic          r_dir_v;
  logic          r_score_left;
  logic          r_score_right;

  logic         w_tick;
  logic [W-1:0] w_left_top;
  logic [W-1:0] w_right_top;
  logic         w_left_ov;
  logic         w_right_ov;
  logic         w_left_hit;
  logic         w_right_hit;
  logic         w_exit_left;
  logic         w_exit_right;
  logic         w_dir_h_nxt;
  logic         w_dir_v_nxt;

  assign w_tick = io_bus.ENABLE && (r_tick_cnt == TICK_LAST);

  // Paddle tops are stored at 2 px resolution.
  assign w_left_top  = {2'b00, io_bus.LEFT_POS, 1'b0};
  assign w_right_top = {2'b00, io_bus.RIGHT_POS, 1'b0};
  assign w_left_ov   = (r_v + BALL_SZ > w_left_top)  && (r_v < w_left_top + PAD_LEN);
  assign w_right_ov  = (r_v + BALL_SZ > w_right_top) && (r_v < w_right_top + PAD_LEN);

  assign w_left_hit   = !r_dir_h && (r_h == LEFT_HIT_H)  && w_left_ov;
  assign w_right_hit  =  r_dir_h && (r_h == RIGHT_HIT_H) && w_right_ov;
  assign w_exit_left  = !r_dir_h && (r_h == '0)    && !w_left_hit;
  assign w_exit_right =  r_dir_h && (r_h == MAX_H) && !w_right_hit;

  assign w_dir_h_nxt = w_left_hit ? 1'b1 : (w_right_hit ? 1'b0 : r_dir_h);
  assign w_dir_v_nxt = (r_dir_v && (r_v == MAX_V)) ? 1'b0 :
                       ((!r_dir_v && (r_v == '0)) ? 1'b1 : r_dir_v);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state       <= S_SERVE;
      r_tick_cnt    <= '0;
      r_serve_cnt   <= '0;
      r_h           <= SRV_H;
      r_v           <= SRV_V;
      r_dir_h       <= 1'b1;
      r_dir_v       <= 1'b1;
      r_score_left  <= 1'b0;
      r_score_right <= 1'b0;
    end else begin
      r_score_left  <= 1'b0;
      r_score_right <= 1'b0;
      if (io_bus.ENABLE) begin
        r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
      end
      case (r_state)
        S_SERVE: begin
          if (w_tick) begin
            if (r_serve_cnt == SERVE_LAST) begin
              r_state     <= S_MOVE;
              r_serve_cnt <= '0;
            end else begin
              r_serve_cnt <= r_serve_cnt + 1'b1;
            end
          end
        end
        S_MOVE: begin
          if (w_tick) begin
            // Score pulse and serve point are loaded together so both show in the SCORED cycle.
            if (w_exit_left) begin
              r_state       <= S_SCORED;
              r_score_right <= 1'b1;
              r_h           <= SRV_H;
              r_v           <= SRV_V;
              r_dir_h       <= 1'b0;
            end else if (w_exit_right) begin
              r_state      <= S_SCORED;
              r_score_left <= 1'b1;
              r_h          <= SRV_H;
              r_v          <= SRV_V;
              r_dir_h      <= 1'b1;
            end else begin
              r_dir_h <= w_dir_h_nxt;
              r_dir_v <= w_dir_v_nxt;
              r_h     <= w_dir_h_nxt ? r_h + 1'b1 : r_h - 1'b1;
              r_v     <= w_dir_v_nxt ? r_v + 1'b1 : r_v - 1'b1;
            end
          end
        end
        S_SCORED: begin
          r_state     <= S_SERVE;
          r_serve_cnt <= '0;
        end
        default: r_state <= S_SERVE;
      endcase
    end
  end

  assign io_bus.BALL_H      = r_h;
  assign io_bus.BALL_V      = r_v;
  assign io_bus.SCORE_LEFT  = r_score_left;
  assign io_bus.SCORE_RIGHT = r_score_right;
endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: per-cycle scoreboard against a behavioural
// model, a vector table for serve/freeze timing, and directed bounce/score sequences.
module tb_ball_engine;
  localparam int TD    = 4;
  localparam int ST    = 2;
  localparam int SCR_W = 800;
  localparam int SCR_H = 480;
  localparam int BS    = 6;
  localparam int PL    = 80;
  localparam int PW    = 6;
  localparam int LX    = 10;
  localparam int RX    = 784;

  typedef struct {
    int phase;  // 0 serve, 1 move, 2 scored
    int cnt;
    int scnt;
    int h;
    int v;
    bit dh;
    bit dv;
    bit sl;
    bit sr;
    int sh;
    int sv;
  } model_t;

  typedef struct { int h; int v; bit sl; bit sr; } exp_t;
  typedef struct { bit en; int ncyc; int h; int v; } vec_t;

  logic CLOCK;
  logic rst0;
  logic rst1;

  ball_engine_if bus0();
  ball_engine_if bus1();

  ball_engine #(.TICK_DIV(4), .SERVE_TICKS(2)) u_dut (
    .CLOCK (CLOCK),
    .RESET (rst0),
    .io_bus(bus0)
  );

  ball_engine #(.TICK_DIV(4), .SERVE_TICKS(2), .SERVE_H(600), .SERVE_V(8)) u_dut_corner (
    .CLOCK (CLOCK),
    .RESET (rst1),
    .io_bus(bus1)
  );

  int     n_checks;
  int     n_errors;
  int     cyc1;
  model_t m0;
  model_t m1;
  exp_t   q0[$];
  exp_t   q1[$];
  vec_t   tbl[8];

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic model_t model_reset(int sh, int sv);
    model_t m;
    m.phase = 0; m.cnt = 0; m.scnt = 0;
    m.h = sh; m.v = sv; m.dh = 1'b1; m.dv = 1'b1;
    m.sl = 1'b0; m.sr = 1'b0; m.sh = sh; m.sv = sv;
    return m;
  endfunction

  function automatic model_t model_next(model_t m, bit en, int lp, int rp);
    model_t n;
    bit tick;
    bit lhit;
    bit rhit;
    n = m;
    n.sl = 1'b0;
    n.sr = 1'b0;
    lhit = 1'b0;
    rhit = 1'b0;
    tick = en && (m.cnt == TD - 1);
    if (en) n.cnt = tick ? 0 : m.cnt + 1;
    if (m.phase == 2) begin
      n.phase = 0;
      n.scnt  = 0;
    end else if (tick && m.phase == 0) begin
      n.scnt = m.scnt + 1;
      if (n.scnt == ST) begin
        n.phase = 1;
        n.scnt  = 0;
      end
    end else if (tick && m.phase == 1) begin
      lhit = !m.dh && (m.h == LX + PW)    && (m.v + BS > 2 * lp) && (m.v < 2 * lp + PL);
      rhit =  m.dh && (m.h + BS == RX)    && (m.v + BS > 2 * rp) && (m.v < 2 * rp + PL);
      if (!m.dh && m.h == 0 && !lhit) begin
        n.phase = 2; n.sr = 1'b1; n.h = m.sh; n.v = m.sv; n.dh = 1'b0;
      end else if (m.dh && m.h == SCR_W - BS && !rhit) begin
        n.phase = 2; n.sl = 1'b1; n.h = m.sh; n.v = m.sv; n.dh = 1'b1;
      end else begin
        if (lhit) n.dh = 1'b1;
        else if (rhit) n.dh = 1'b0;
        if (m.dv && m.v == SCR_H - BS) n.dv = 1'b0;
        else if (!m.dv && m.v == 0) n.dv = 1'b1;
        n.h = n.dh ? m.h + 1 : m.h - 1;
        n.v = n.dv ? m.v + 1 : m.v - 1;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] pack(int h, int v, bit sl, bit sr);
    return {8'd0, sl, sr, 11'(v), 11'(h)};
  endfunction

  function automatic logic [31:0] dut0();
    return {8'd0, bus0.SCORE_LEFT, bus0.SCORE_RIGHT, bus0.BALL_V, bus0.BALL_H};
  endfunction

  function automatic logic [31:0] dut1();
    return {8'd0, bus1.SCORE_LEFT, bus1.SCORE_RIGHT, bus1.BALL_V, bus1.BALL_H};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t: got h=%0d v=%0d sl=%b sr=%b, want h=%0d v=%0d sl=%b sr=%b",
               name, $time, act[10:0], act[21:11], act[23], act[22],
               exp[10:0], exp[21:11], exp[23], exp[22]);
    end
  endtask

  // One clock: model predicts the post-edge outputs, DUT is compared after the edge.
  task automatic step();
    exp_t e;
    if (rst0) m0 = model_reset(397, 237);
    else      m0 = model_next(m0, bus0.ENABLE, int'(bus0.LEFT_POS), int'(bus0.RIGHT_POS));
    if (rst1) m1 = model_reset(600, 8);
    else      m1 = model_next(m1, bus1.ENABLE, int'(bus1.LEFT_POS), int'(bus1.RIGHT_POS));
    e.h = m0.h; e.v = m0.v; e.sl = m0.sl; e.sr = m0.sr;
    q0.push_back(e);
    e.h = m1.h; e.v = m1.v; e.sl = m1.sl; e.sr = m1.sr;
    q1.push_back(e);
    @(posedge CLOCK);
    #1;
    if (!rst1) cyc1++;
    e = q0.pop_front();
    check("sb0", dut0(), pack(e.h, e.v, e.sl, e.sr));
    e = q1.pop_front();
    check("sb1", dut1(), pack(e.h, e.v, e.sl, e.sr));
    if (cyc1 == 720)  check("corner_rhit_at", dut1(), pack(778, 186, 1'b0, 1'b0));
    if (cyc1 == 724)  check("corner_rhit_after", dut1(), pack(777, 187, 1'b0, 1'b0));
    if (cyc1 == 1872) check("corner_bottom", dut1(), pack(490, 474, 1'b0, 1'b0));
    if (cyc1 == 3768) check("corner_at", dut1(), pack(16, 0, 1'b0, 1'b0));
    if (cyc1 == 3772) check("corner_after", dut1(), pack(17, 1, 1'b0, 1'b0));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    run(2);
    check("reset0", dut0(), pack(397, 237, 1'b0, 1'b0));
    rst0 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc1     = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.ENABLE = 1'b1; bus0.LEFT_POS = 8'd0; bus0.RIGHT_POS = 8'd0;
    bus1.ENABLE = 1'b1; bus1.LEFT_POS = 8'd0; bus1.RIGHT_POS = 8'd80;
    m0 = model_reset(397, 237);
    m1 = model_reset(600, 8);

    tbl[0] = '{en: 1'b1, ncyc: 4,  h: 397, v: 237};
    tbl[1] = '{en: 1'b1, ncyc: 4,  h: 397, v: 237};
    tbl[2] = '{en: 1'b1, ncyc: 3,  h: 397, v: 237};
    tbl[3] = '{en: 1'b1, ncyc: 1,  h: 398, v: 238};
    tbl[4] = '{en: 1'b1, ncyc: 4,  h: 399, v: 239};
    tbl[5] = '{en: 1'b0, ncyc: 20, h: 399, v: 239};
    tbl[6] = '{en: 1'b1, ncyc: 3,  h: 399, v: 239};
    tbl[7] = '{en: 1'b1, ncyc: 1,  h: 400, v: 240};

    run(2);
    check("reset_init0", dut0(), pack(397, 237, 1'b0, 1'b0));
    check("reset_init1", dut1(), pack(600, 8, 1'b0, 1'b0));
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Serve hold, first moves, and a 20-cycle freeze.
    for (int i = 0; i < 8; i++) begin
      bus0.ENABLE = tbl[i].en;
      run(tbl[i].ncyc);
      check($sformatf("vec%0d", i), dut0(), pack(tbl[i].h, tbl[i].v, 1'b0, 1'b0));
    end

    // Bottom wall then right paddle hit (top row 330 overlaps V=330).
    bus0.ENABLE = 1'b1;
    bus0.RIGHT_POS = 8'd165;
    reset0();
    run(952); check("bottom_473", dut0(), pack(633, 473, 1'b0, 1'b0));
    run(4);   check("bottom_474", dut0(), pack(634, 474, 1'b0, 1'b0));
    run(4);   check("bottom_back", dut0(), pack(635, 473, 1'b0, 1'b0));
    run(568); check("rhit_before", dut0(), pack(777, 331, 1'b0, 1'b0));
    run(4);   check("rhit_at", dut0(), pack(778, 330, 1'b0, 1'b0));
    run(4);   check("rhit_after", dut0(), pack(777, 329, 1'b0, 1'b0));

    // Right paddle miss: exit at 794, score pulse, re-serve toward +H with dir_v kept.
    bus0.RIGHT_POS = 8'd0;
    reset0();
    run(1596); check("miss_edge", dut0(), pack(794, 314, 1'b0, 1'b0));
    run(4);    check("score_left", dut0(), pack(397, 237, 1'b1, 1'b0));
    run(1);    check("score_end", dut0(), pack(397, 237, 1'b0, 1'b0));
    run(10);   check("reserve_hold", dut0(), pack(397, 237, 1'b0, 1'b0));
    run(1);    check("reserve_move", dut0(), pack(398, 236, 1'b0, 1'b0));

    // Asynchronous reset mid-move.
    run(8);
    check("pre_reset", dut0(), pack(400, 234, 1'b0, 1'b0));
    #2;
    rst0 = 1'b1;
    #1;
    check("async_reset", dut0(), pack(397, 237, 1'b0, 1'b0));
    run(2);
    rst0 = 1'b0;
    run(12);
    check("post_reset_move", dut0(), pack(398, 238, 1'b0, 1'b0));

    // Random paddles and enable; inputs change every cycle, sampled only on ticks.
    for (int i = 0; i < 6000; i++) begin
      bus0.ENABLE    = ($urandom_range(0, 9) != 0);
      bus0.LEFT_POS  = 8'($urandom_range(0, 255));
      bus0.RIGHT_POS = 8'($urandom_range(0, 255));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
